// File: rtl/oled_pkg.sv
// Shared constants and FSM state encoding for the OLEDrgb SSD1331 command path.
package oled_pkg;

   localparam logic [7:0] CMD_DRAW_RECT      = 8'h22;
   localparam int         OLED_CMD_MAX_BYTES = 11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      HOLD     = 3'd4,
      GAP      = 3'd5
   } oled_state_t;

   // Requested byte count limited to what the bundle can hold.
   function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_bytes);
      logic [3:0] max_s;
      max_s = 4'(max_bytes);
      return (len > max_s) ? max_s : len;
   endfunction

endpackage

// File: rtl/oled_sclk_tick.sv
// Half-period timer for the SPI clock: tick is high on the last cycle of each
// CLK_DIV-cycle phase; clear reloads it so every FSM state starts a fresh phase.
module oled_sclk_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] LOAD = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt_r;

   // Down-counter reloaded on clear, wrapping into the next phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_r <= LOAD;
      end else if (clear) begin
         div_cnt_r <= LOAD;
      end else begin
         div_cnt_r <= div_cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
      end
   end

   assign tick = (div_cnt_r == {DIV_W{1'b0}});

endmodule

// File: rtl/oled_cmd_spi_sender.sv
// Serialises an up-to-MAX_BYTES SSD1331 command bundle onto the OLEDrgb SPI pins
// (mode 3, MSB first, byte 0 first, D/C held in command mode).
module oled_cmd_spi_sender
   import oled_pkg::*;
#(
   parameter int MAX_BYTES = OLED_CMD_MAX_BYTES,
   parameter int CLK_DIV   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [8*MAX_BYTES-1:0] cmd_data,
   input  logic [3:0]             cmd_len,
   output logic                   busy,
   output logic                   done,
   output logic                   oled_cs_n,
   output logic                   oled_sclk,
   output logic                   oled_sdin,
   output logic                   oled_dc
);

   localparam int SH_W = 8 * MAX_BYTES;

   oled_state_t     state_r;
   logic [SH_W-1:0] shift_r;
   logic [SH_W-1:0] shift_next_s;
   logic [3:0]      len_r;
   logic [3:0]      len_clamped_s;
   logic [2:0]      bit_cnt_r;
   logic [3:0]      byte_cnt_r;
   logic            tick_s;
   logic            clear_s;
   logic            last_byte_s;

   // Held in reload while idle, so the first phase after accept is a full CLK_DIV.
   assign clear_s       = (state_r == IDLE) || tick_s;
   assign shift_next_s  = shift_r >> 8;
   assign last_byte_s   = (byte_cnt_r == (len_r - 4'd1));
   assign len_clamped_s = clamp_len(cmd_len, MAX_BYTES);

   oled_sclk_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_s),
      .tick  (tick_s)
   );

   // Transfer FSM with registered SPI pins, handshake and byte/bit bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         oled_cs_n  <= 1'b1;
         oled_sclk  <= 1'b1;
         oled_sdin  <= 1'b0;
         oled_dc    <= 1'b0;
         shift_r    <= {SH_W{1'b0}};
         len_r      <= 4'd0;
         bit_cnt_r  <= 3'd7;
         byte_cnt_r <= 4'd0;
      end else begin
         done    <= 1'b0;
         oled_dc <= 1'b0;
         case (state_r)
            IDLE: begin
               // Not ready while idle only happens right after a zero-length bundle.
               if (!cmd_ready) begin
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end else if (cmd_valid) begin
                  shift_r    <= cmd_data;
                  len_r      <= len_clamped_s;
                  bit_cnt_r  <= 3'd7;
                  byte_cnt_r <= 4'd0;
                  cmd_ready  <= 1'b0;
                  busy       <= 1'b1;
                  if (len_clamped_s == 4'd0) begin
                     done <= 1'b1;
                  end else begin
                     state_r   <= SETUP;
                     oled_cs_n <= 1'b0;
                     oled_sclk <= 1'b1;
                  end
               end
            end
            SETUP: begin
               if (tick_s) begin
                  state_r   <= SHIFT_LO;
                  oled_sclk <= 1'b0;
                  oled_sdin <= shift_r[7];
               end
            end
            SHIFT_LO: begin
               if (tick_s) begin
                  state_r   <= SHIFT_HI;
                  oled_sclk <= 1'b1;
               end
            end
            SHIFT_HI: begin
               if (tick_s) begin
                  if (bit_cnt_r == 3'd0) begin
                     if (last_byte_s) begin
                        state_r <= HOLD;
                     end else begin
                        state_r    <= SHIFT_LO;
                        oled_sclk  <= 1'b0;
                        shift_r    <= shift_next_s;
                        oled_sdin  <= shift_next_s[7];
                        bit_cnt_r  <= 3'd7;
                        byte_cnt_r <= byte_cnt_r + 4'd1;
                     end
                  end else begin
                     state_r   <= SHIFT_LO;
                     oled_sclk <= 1'b0;
                     oled_sdin <= shift_r[bit_cnt_r - 3'd1];
                     bit_cnt_r <= bit_cnt_r - 3'd1;
                  end
               end
            end
            HOLD: begin
               if (tick_s) begin
                  state_r   <= GAP;
                  oled_cs_n <= 1'b1;
                  done      <= 1'b1;
               end
            end
            GAP: begin
               if (tick_s) begin
                  state_r   <= IDLE;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end
            end
            default: begin
               state_r   <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               oled_cs_n <= 1'b1;
               oled_sclk <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oled_cmd_spi_sender.sv
// Self-checking bench: two sender instances (CLK_DIV 2 and 1) compared against a
// frame-level reference computed from the bundle bytes and clamped length.
module tb_oled_cmd_spi_sender;

   localparam int MB = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic [87:0]   cmd_data = '0;
   logic [3:0]    cmd_len = 4'd0;

   logic rdy2, busy2, done2, cs2, sclk2, sdin2, dc2;
   logic rdy1, busy1, done1, cs1, sclk1, sdin1, dc1;
   logic rdy_m, busy_m, done_m, cs_m, sclk_m, sdin_m, dc_m;
   int   sel_div = 2;

   always #5 clk = ~clk;

   oled_cmd_spi_sender #(.MAX_BYTES(MB), .CLK_DIV(2)) dut2 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
      .cmd_data(cmd_data), .cmd_len(cmd_len), .busy(busy2), .done(done2),
      .oled_cs_n(cs2), .oled_sclk(sclk2), .oled_sdin(sdin2), .oled_dc(dc2));

   oled_cmd_spi_sender #(.MAX_BYTES(MB), .CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
      .cmd_data(cmd_data), .cmd_len(cmd_len), .busy(busy1), .done(done1),
      .oled_cs_n(cs1), .oled_sclk(sclk1), .oled_sdin(sdin1), .oled_dc(dc1));

   always_comb begin
      if (sel_div == 1) {rdy_m, busy_m, done_m, cs_m, sclk_m, sdin_m, dc_m} = {rdy1, busy1, done1, cs1, sclk1, sdin1, dc1};
      else              {rdy_m, busy_m, done_m, cs_m, sclk_m, sdin_m, dc_m} = {rdy2, busy2, done2, cs2, sclk2, sdin2, dc2};
   end

   // Bus monitor on the selected instance, sampled on the falling edge.
   int   cyc = 0, rise_cnt = 0, done_cnt = 0, frames = 0, dc_bad = 0, idle_glitch = 0;
   int   low_run = 0, hi_run = 1000, last_low = 0, last_gap = 0;
   int   sp_min = 1000, sp_max = 0, last_rise = 0;
   bit   have_rise = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b1;
   logic bits[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (dc_m) dc_bad = dc_bad + 1;
      if (done_m) done_cnt = done_cnt + 1;
      if (cs_m) begin
         if (!prev_cs) begin
            last_low = low_run;
            frames   = frames + 1;
            hi_run   = 0;
         end
         hi_run = hi_run + 1;
         if (!sclk_m) idle_glitch = idle_glitch + 1;
      end else begin
         if (prev_cs) begin
            last_gap  = hi_run;
            low_run   = 0;
            sp_min    = 1000;
            sp_max    = 0;
            have_rise = 1'b0;
         end
         low_run = low_run + 1;
      end
      if (!prev_sclk && sclk_m) begin
         rise_cnt = rise_cnt + 1;
         bits.push_back(sdin_m);
         if (have_rise) begin
            if (cyc - last_rise < sp_min) sp_min = cyc - last_rise;
            if (cyc - last_rise > sp_max) sp_max = cyc - last_rise;
         end
         have_rise = 1'b1;
         last_rise = cyc;
      end
      prev_cs   = cs_m;
      prev_sclk = sclk_m;
   end

   int n_cmp = 0, n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input bit both);
      int t = 0;
      while (!(rdy_m && (!both || (rdy1 && rdy2))) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) check_eq("ready_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [87:0] rand_bundle();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[87:0];
   endfunction

   // Reference: bundle byte k, MSB first, sent in order k = 0..n-1.
   task automatic check_bits(input string tag, input int start, input logic [87:0] d, input int n);
      logic [7:0] obs;
      logic [7:0] exp;
      if (bits.size() < start + 8 * n) begin
         check_eq({tag, "_bitcount"}, bits.size(), start + 8 * n);
      end else begin
         for (int k = 0; k < n; k++) begin
            obs = 8'd0;
            for (int j = 0; j < 8; j++) obs = {obs[6:0], bits[start + 8 * k + j]};
            exp = d[8 * k +: 8];
            check_eq($sformatf("%s_byte%0d", tag, k), obs, exp);
         end
      end
   endtask

   task automatic send(input logic [87:0] d, input logic [3:0] l);
      wait_ready(1'b1);
      cmd_data  = d;
      cmd_len   = l;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_data  = rand_bundle();
      cmd_len   = 4'($urandom_range(0, 15));
      check_eq("accept_ready_low", rdy_m, 1'b0);
      check_eq("accept_busy_high", busy_m, 1'b1);
   endtask

   task automatic run_frame(input string tag, input logic [87:0] d, input logic [3:0] l);
      int n, dv, r0, d0, f0, b0, t;
      n  = (l > 4'd11) ? 11 : int'(l);
      dv = sel_div;
      wait_ready(1'b1);
      r0 = rise_cnt; d0 = done_cnt; f0 = frames; b0 = bits.size();
      send(d, l);
      if (n == 0) begin
         @(negedge clk);
         check_eq({tag, "_done_next"}, done_m, 1'b1);
         @(negedge clk);
         check_eq({tag, "_done_one"}, done_m, 1'b0);
         check_eq({tag, "_ready_back"}, rdy_m, 1'b1);
      end
      t = 0;
      while (!(done_cnt > d0 && rdy_m) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check_eq({tag, "_finished"}, (t < 2000), 1'b1);
      check_eq({tag, "_rises"}, rise_cnt - r0, 8 * n);
      check_eq({tag, "_done_cnt"}, done_cnt - d0, 1);
      check_eq({tag, "_dc_low"}, dc_bad, 0);
      check_eq({tag, "_no_idle_glitch"}, idle_glitch, 0);
      if (n == 0) begin
         check_eq({tag, "_no_frame"}, frames - f0, 0);
      end else begin
         check_eq({tag, "_frames"}, frames - f0, 1);
         check_eq({tag, "_cs_low"}, last_low, (2 + 16 * n) * dv);
         check_eq({tag, "_sclk_min"}, sp_min, 2 * dv);
         check_eq({tag, "_sclk_max"}, sp_max, 2 * dv);
         check_bits(tag, b0, d, n);
      end
   endtask

   logic [87:0] rect;
   logic [87:0] d1, d2;

   initial begin
      int b0, f0, d0, t, r0;
      rect = {8'h3E, 8'h20, 8'h00, 8'h3E, 8'h20, 8'h00, 8'h2F, 8'h14, 8'h10, 8'h00, 8'h22};

      repeat (3) @(negedge clk);
      check_eq("reset_div2", {rdy2, busy2, done2, cs2, sclk2, sdin2, dc2}, 7'b1001100);
      check_eq("reset_div1", {rdy1, busy1, done1, cs1, sclk1, sdin1, dc1}, 7'b1001100);
      rst = 1'b0;
      @(negedge clk);

      sel_div = 2;
      run_frame("rect", rect, 4'd11);
      run_frame("a5", {80'd0, 8'hA5}, 4'd1);
      run_frame("len0", rand_bundle(), 4'd0);

      // Second bundle held valid throughout the first transfer.
      wait_ready(1'b1);
      d1 = rand_bundle(); d2 = rand_bundle();
      b0 = bits.size(); f0 = frames; d0 = done_cnt;
      cmd_data = d1; cmd_len = 4'd3; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_data = d2; cmd_len = 4'd2;
      t = 0;
      while (!rdy_m && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check_eq("hold_ready_seen", (t < 2000), 1'b1);
      check_eq("hold_first_done", done_cnt - d0, 1);
      check_eq("hold_first_frame_only", frames - f0, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check_eq("hold_second_accepted", rdy_m, 1'b0);
      t = 0;
      while (!(done_cnt > d0 + 1 && rdy_m) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check_eq("hold_second_finished", (t < 2000), 1'b1);
      check_eq("hold_gap", (last_gap >= 2), 1'b1);
      check_eq("hold_cs_low2", last_low, (2 + 16 * 2) * 2);
      check_bits("hold_f1", b0, d1, 3);
      check_bits("hold_f2", b0 + 24, d2, 2);

      // Reset during byte 4 of a full bundle.
      wait_ready(1'b1);
      r0 = rise_cnt;
      send(rand_bundle(), 4'd11);
      t = 0;
      while (rise_cnt < r0 + 35 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      check_eq("rst_async_outputs", {cs_m, sclk_m, busy_m, done_m, rdy_m}, 5'b11001);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_no_done", done_cnt - d0, 0);
      run_frame("after_rst", rand_bundle(), 4'd11);

      sel_div = 1;
      run_frame("div1_clamp", rand_bundle(), 4'd15);

      for (int i = 0; i < 8; i++) begin
         wait_ready(1'b1);
         sel_div = ($urandom_range(0, 1) == 0) ? 1 : 2;
         run_frame($sformatf("rand%0d", i), rand_bundle(), 4'($urandom_range(0, 15)));
      end

      wait_ready(1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
